// File: rtl/divider_core.sv
`default_nettype none
// ============================================================================
//  Module      : divider_core
//  Description : Programmable clock divider fed by the 32-bit serial config
//                word; new settings are applied glitch-free at period ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_core #(
    parameter int SYNC_STAGES = 2,
    parameter int RATIO_WIDTH = 30
) (
    input  logic        sys_clock,
    input  logic        sys_reset_n,
    input  logic [31:0] divide_word,
    input  logic        load_request,
    output logic        div_out,
    output logic        div_pulse,
    output logic        load_ack,
    output logic        load_pending,
    output logic        run_active,
    output logic        ratio_error
);

    localparam logic [0:0]             c_STATE_IDLE = 1'b0;
    localparam logic [0:0]             c_STATE_RUN  = 1'b1;
    localparam int                     c_EN_BIT     = 31;
    localparam int                     c_INV_BIT    = 30;
    localparam logic [RATIO_WIDTH-1:0] c_ONE        = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] c_TWO        = RATIO_WIDTH'(2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [0:0]             r_state;
    logic [RATIO_WIDTH-1:0] r_count;
    logic [RATIO_WIDTH-1:0] r_act_n;
    logic                   r_act_inv;
    logic [31:0]            r_shadow;
    logic                   r_pending;
    logic                   r_ack;
    logic                   r_div_out;
    logic                   r_div_pulse;
    logic                   r_ratio_error;

    logic                   w_edge;
    logic                   w_boundary;
    logic                   w_apply;
    logic [RATIO_WIDTH-1:0] w_sh_n;
    logic                   w_sh_en;
    logic                   w_sh_ok;
    logic [0:0]             w_state_next;
    logic [RATIO_WIDTH-1:0] w_count_next;
    logic [RATIO_WIDTH-1:0] w_n_next;
    logic                   w_inv_next;
    logic                   w_run_next;
    logic                   w_div_next;
    logic                   w_pulse_next;

    always_comb begin
        w_edge       = r_sync[SYNC_STAGES-1] & ~r_sync_d;
        w_boundary   = (r_count == (r_act_n - c_ONE));
        w_apply      = r_pending & ((r_state == c_STATE_IDLE) | w_boundary);
        w_sh_n       = r_shadow[RATIO_WIDTH-1:0];
        w_sh_en      = r_shadow[c_EN_BIT];
        w_sh_ok      = w_sh_en & (w_sh_n >= c_TWO);
        w_state_next = r_state;
        w_count_next = '0;
        w_n_next     = r_act_n;
        w_inv_next   = r_act_inv;
        if (w_apply) begin
            // A fresh config always restarts the period at count 0.
            w_n_next     = w_sh_n;
            w_inv_next   = r_shadow[c_INV_BIT];
            w_state_next = w_sh_ok ? c_STATE_RUN : c_STATE_IDLE;
        end else if (r_state == c_STATE_RUN) begin
            w_count_next = w_boundary ? '0 : (r_count + c_ONE);
        end
        w_run_next   = (w_state_next == c_STATE_RUN);
        w_div_next   = w_run_next ? ((w_count_next < (w_n_next >> 1)) ^ w_inv_next)
                                  : w_inv_next;
        w_pulse_next = w_run_next & (w_count_next == '0);
    end

    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sync        <= '0;
            r_sync_d      <= 1'b0;
            r_state       <= c_STATE_IDLE;
            r_count       <= '0;
            r_act_n       <= '0;
            r_act_inv     <= 1'b0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_ack         <= 1'b0;
            r_div_out     <= 1'b0;
            r_div_pulse   <= 1'b0;
            r_ratio_error <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], load_request};
            r_sync_d    <= r_sync[SYNC_STAGES-1];
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_div_out   <= w_div_next;
            r_div_pulse <= w_pulse_next;
            r_ack       <= w_apply;
            if (w_apply) begin
                r_act_n   <= w_sh_n;
                r_act_inv <= r_shadow[c_INV_BIT];
                if (w_sh_ok) begin
                    r_ratio_error <= 1'b0;
                end else if (w_sh_en) begin
                    r_ratio_error <= 1'b1;
                end
            end
            // A capture landing on the apply edge stays pending for the next boundary.
            if (w_edge) begin
                r_shadow  <= divide_word;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign div_out      = r_div_out;
    assign div_pulse    = r_div_pulse;
    assign load_ack     = r_ack;
    assign load_pending = r_pending;
    assign run_active   = (r_state == c_STATE_RUN);
    assign ratio_error  = r_ratio_error;

endmodule
`default_nettype wire

// File: tb/tb_divider_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_core
//  Description : Self-checking bench for divider_core with a period-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_core;

    localparam int c_S = 2;

    logic        sys_clock    = 1'b0;
    logic        sys_reset_n  = 1'b0;
    logic        load_request = 1'b0;
    logic [31:0] divide_word  = 32'h0;
    wire         div_out, div_pulse, load_ack, load_pending, run_active, ratio_error;

    int errors = 0;
    int checks = 0;

    divider_core #(.SYNC_STAGES(c_S), .RATIO_WIDTH(30)) dut (
        .sys_clock    (sys_clock),
        .sys_reset_n  (sys_reset_n),
        .divide_word  (divide_word),
        .load_request (load_request),
        .div_out      (div_out),
        .div_pulse    (div_pulse),
        .load_ack     (load_ack),
        .load_pending (load_pending),
        .run_active   (run_active),
        .ratio_error  (ratio_error)
    );

    always #5 sys_clock = ~sys_clock;

    // Reference model: phase within the current output period plus config.
    bit          m_run, m_pend, m_err, m_ack, m_inv;
    int unsigned m_n, m_phase;
    logic [31:0] m_shadow;
    bit          m_hist [0:c_S+1];

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_err = 0; m_ack = 0; m_inv = 0;
        m_n = 0; m_phase = 0; m_shadow = 32'h0;
        for (int i = 0; i <= c_S + 1; i++) m_hist[i] = 0;
    endtask

    task automatic model_edge();
        bit cap, apply;
        for (int i = c_S + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = load_request;
        cap   = m_hist[c_S] && !m_hist[c_S+1];
        apply = m_pend && (!m_run || (m_phase == m_n - 1));
        m_ack = apply;
        if (apply) begin
            m_n   = int'(m_shadow[29:0]);
            m_inv = m_shadow[30];
            if (m_shadow[31] && m_n >= 2) begin
                m_run = 1; m_err = 0;
            end else begin
                m_run = 0;
                if (m_shadow[31]) m_err = 1;
            end
            m_phase = 0;
            m_pend  = 0;
        end else if (m_run) begin
            m_phase = (m_phase + 1) % m_n;
        end
        if (cap) begin
            m_shadow = divide_word;
            m_pend   = 1;
        end
    endtask

    function automatic logic [5:0] exp_vec();
        logic d;
        d = m_run ? (((m_phase < m_n / 2) ? 1'b1 : 1'b0) ^ m_inv) : m_inv;
        return {d, (m_run && m_phase == 0), m_ack, m_pend, m_run, m_err};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {div_out, div_pulse, load_ack, load_pending, run_active, ratio_error};
    endfunction

    task automatic cycle();
        @(posedge sys_clock);
        model_edge();
        @(negedge sys_clock);
    endtask

    task automatic test_reset();
        sys_reset_n = 0;
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        checks++;
        if (obs_vec() !== 6'b0)
            $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 6'b0);
        model_reset();
        sys_reset_n = 1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int         ack_edge = -1;
        int         k;
        logic [3:0] pat = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            if (c == 0) begin divide_word = 32'h8000_0004; load_request = 1; end
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack && ack_edge < 0) ack_edge = c + 1;
            if (ack_edge > 0) begin
                k = c + 1 - ack_edge;
                checks++;
                if (div_out !== pat[k % 4] || div_pulse !== (k % 4 == 0)) begin
                    errors++;
                    $display("FAIL basic_pattern k=%0d: got out=%b pulse=%b expected out=%b pulse=%b",
                             k, div_out, div_pulse, pat[k % 4], (k % 4 == 0));
                end
            end
        end
        checks++;
        if (ack_edge !== 4 || run_active !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack_latency: got edge=%0d run=%b expected edge=4 run=1", ack_edge, run_active);
        end
    endtask

    task automatic test_retarget();
        int acks = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) begin divide_word = 32'h8000_0007; load_request = 1; end
            if (c == 3) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL retarget_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack) begin
                acks++;
                checks++;
                if (div_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL retarget_ack_pulse: got pulse=%b expected 1", div_pulse);
                end
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL retarget_ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_invert();
        int         ack_edge = -1;
        int         k;
        logic [5:0] pat = 6'b111000;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin divide_word = 32'h4000_0006; load_request = 1; end
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL invert_idle_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (div_out !== 1'b1 || run_active !== 1'b0) begin
            errors++;
            $display("FAIL invert_idle_level: got out=%b run=%b expected out=1 run=0", div_out, run_active);
        end
        for (int c = 0; c < 24; c++) begin
            if (c == 0) begin divide_word = 32'hC000_0006; load_request = 1; end
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL invert_run_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack && ack_edge < 0) ack_edge = c;
            if (ack_edge >= 0) begin
                k = c - ack_edge;
                checks++;
                if (div_out !== pat[k % 6]) begin
                    errors++;
                    $display("FAIL invert_pattern k=%0d: got %b expected %b", k, div_out, pat[k % 6]);
                end
            end
        end
    endtask

    task automatic test_ratio_error();
        for (int c = 0; c < 20; c++) begin
            if (c == 0) begin divide_word = 32'h8000_0001; load_request = 1; end
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio_bad_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (ratio_error !== 1'b1 || div_out !== 1'b0 || run_active !== 1'b0) begin
            errors++;
            $display("FAIL ratio_error_set: got err=%b out=%b run=%b expected 1 0 0",
                     ratio_error, div_out, run_active);
        end
        for (int c = 0; c < 14; c++) begin
            if (c == 0) begin divide_word = 32'h8000_0002; load_request = 1; end
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio_clear_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (ratio_error !== 1'b0 || run_active !== 1'b1) begin
            errors++;
            $display("FAIL ratio_error_clear: got err=%b run=%b expected 0 1", ratio_error, run_active);
        end
    endtask

    task automatic test_double_load();
        bit got = 0;
        int acks = 0;
        int p0 = -1, p1 = -1;
        divide_word = 32'h8000_0064; load_request = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL double_setup c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack) got = 1;
        end
        load_request = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL double_setup_timeout: got no ack expected ack within 20 cycles");
        end
        for (int c = 0; c < 120; c++) begin
            if (c == 0) begin divide_word = 32'h8000_0010; load_request = 1; end
            if (c == 2) load_request = 0;
            if (c == 4) begin divide_word = 32'h8000_0003; load_request = 1; end
            if (c == 6) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL double_model c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack) acks++;
            if (c >= 110 && div_pulse) begin
                if (p0 < 0) p0 = c; else if (p1 < 0) p1 = c;
            end
        end
        checks++;
        if (acks != 1 || (p1 - p0) != 3) begin
            errors++;
            $display("FAIL double_single_ack: got acks=%0d period=%0d expected acks=1 period=3", acks, p1 - p0);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          hi, gap;
        for (int it = 0; it < 10; it++) begin
            w        = 32'h0;
            w[31]    = ($urandom_range(0, 5) != 0);
            w[30]    = 1'($urandom_range(0, 1));
            w[29:0]  = 30'($urandom_range(0, 12));
            hi       = $urandom_range(1, 4);
            gap      = $urandom_range(hi + 1, 40);
            for (int c = 0; c < gap; c++) begin
                if (c == 0) begin divide_word = w; load_request = 1; end
                if (c == hi) load_request = 0;
                cycle();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random it=%0d word=%h c=%0d: got %b expected %b",
                             it, w, c, obs_vec(), exp_vec());
                end
            end
        end
        for (int c = 0; c < 30; c++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_drain c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int acks = 0;
        divide_word = 32'h8000_0008; load_request = 1;
        for (int c = 0; c < 20 && !found; c++) begin
            if (c == 2) load_request = 0;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_setup c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_pending) found = 1;
        end
        load_request = 0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_pending: got no pending expected pending within 20 cycles");
        end
        #2 sys_reset_n = 0;
        #1;
        checks++;
        if (obs_vec() !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected %b", obs_vec(), 6'b0);
        end
        repeat (2) @(negedge sys_clock);
        model_reset();
        sys_reset_n = 1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after c=%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (load_ack) acks++;
        end
        checks++;
        if (acks != 0 || run_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_ack: got acks=%0d run=%b expected 0 0", acks, run_active);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_retarget();
        test_invert();
        test_ratio_error();
        test_double_load();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
